// File: rtl/dvp_cam_emulator.sv
// dvp_cam_emulator: synthetic OV7670-style DVP camera source.
// Drives VSYNC / HREF / 8-bit data with RGB565 test patterns, two bytes per
// pixel, one byte per clk. It stands in for the camera pins so the capture
// path can run without a sensor.
// Optional feature: define DVP_SCROLL_EN to scroll patterns 0-2 left by one
// pixel per frame, using a 10-bit frame counter.
module dvp_cam_emulator #(
  parameter int H_ACTIVE = 640,  // pixels per active line, multiple of 8
  parameter int H_BLANK  = 144,  // HREF-low cycles after each line's data
  parameter int V_ACTIVE = 480,  // active lines per frame
  parameter int VS_LINES = 3,    // lines with VSYNC high at frame start
  parameter int V_BACK   = 17,   // blank lines between VSYNC and active
  parameter int V_FRONT  = 10    // blank lines after active
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int HCNT_W    = $clog2(LINE_LEN);
  localparam int MAX_VA    = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int MAX_VB    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_VA > MAX_VB) ? MAX_VA : MAX_VB;
  localparam int LCNT_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int BAR_W     = H_ACTIVE / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t              state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [LCNT_W-1:0]   last_line_idx;
  logic                line_end;
  logic                last_line;
  logic                latch_inputs;
  logic [1:0]          sel_q;
  logic [15:0]         solid_q;
  logic [15:0]         px_x;
  logic [15:0]         px_xs;
  logic [15:0]         bar_idx;
  logic                y_bit3;
  logic [15:0]         pixel;

  assign line_end  = (hcnt_q == HCNT_W'(LINE_LEN - 1));
  assign last_line = (lcnt_q == last_line_idx);

  // Index of the final line of the current state, used to end the state.
  always_comb begin
    last_line_idx = '0;
    case (state_q)
      S_VSYNC:  last_line_idx = LCNT_W'(VS_LINES - 1);
      S_VBACK:  last_line_idx = LCNT_W'(V_BACK - 1);
      S_ACTIVE: last_line_idx = LCNT_W'(V_ACTIVE - 1);
      S_VFRONT: last_line_idx = LCNT_W'(V_FRONT - 1);
      default:  last_line_idx = '0;
    endcase
  end

  // State and counter registers; reset drops every output to 0 at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Next-state logic: walk the frame line by line, chaining frames while en.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    latch_inputs = 1'b0;
    if (state_q == S_IDLE) begin
      hcnt_d = '0;
      lcnt_d = '0;
      if (en) begin
        state_d      = S_VSYNC;
        latch_inputs = 1'b1;
      end
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + HCNT_W'(1);
      if (line_end) begin
        lcnt_d = last_line ? '0 : lcnt_q + LCNT_W'(1);
      end
      if (line_end && last_line) begin
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          S_VFRONT: begin
            if (en) begin
              state_d      = S_VSYNC;
              latch_inputs = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  // Pattern controls are captured only at frame start, so mid-frame changes
  // never disturb the frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= 2'd0;
      solid_q <= 16'h0000;
    end else if (latch_inputs) begin
      sel_q   <= pattern_sel;
      solid_q <= solid_rgb;
    end
  end

  // Pixel column: two bytes per pixel.
  assign px_x = 16'(hcnt_q[HCNT_W-1:1]);

`ifdef DVP_SCROLL_EN
  logic [9:0] fc_q;

  // Frame counter advances once per completed frame and sets the scroll offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_q <= 10'd0;
    end else if (frame_done) begin
      fc_q <= fc_q + 10'd1;
    end
  end

  assign px_xs = (px_x + 16'(fc_q)) % 16'(H_ACTIVE);
`else
  assign px_xs = px_x;
`endif

  // Bit 3 of the active line index, for the checkerboard.
  assign y_bit3  = |(LCNT_W'(lcnt_q >> 3) & LCNT_W'(1));
  assign bar_idx = px_xs / 16'(BAR_W);

  // RGB565 colour of the current pixel for the latched pattern.
  always_comb begin
    pixel = 16'h0000;
    case (sel_q)
      2'd0: begin
        case (bar_idx)
          16'd0:   pixel = 16'hFFFF;
          16'd1:   pixel = 16'hFFE0;
          16'd2:   pixel = 16'h07FF;
          16'd3:   pixel = 16'h07E0;
          16'd4:   pixel = 16'hF81F;
          16'd5:   pixel = 16'hF800;
          16'd6:   pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {px_xs[4:0], px_xs[5:0], px_xs[4:0]};
      2'd2:    pixel = (px_xs[3] ^ y_bit3) ? 16'hFFFF : 16'h0000;
      default: pixel = solid_q;
    endcase
  end

  // Camera outputs decoded from the registered state and counters.
  always_comb begin
    vsync      = (state_q == S_VSYNC);
    busy       = (state_q != S_IDLE);
    href       = (state_q == S_ACTIVE) && (hcnt_q < HCNT_W'(2 * H_ACTIVE));
    frame_done = (state_q == S_VFRONT) && line_end && last_line;
    data       = 8'h00;
    if (href) begin
      data = hcnt_q[0] ? pixel[7:0] : pixel[15:8];
    end
  end

endmodule

// File: tb/tb_dvp_cam_emulator.sv
// Testbench for dvp_cam_emulator: directed frame-timing checks plus a
// randomized run, all compared against a frame-timeline reference model.
module tb_dvp_cam_emulator;

  localparam int HA = 8;
  localparam int HB = 4;
  localparam int VA = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LL = 2 * HA + HB;
  localparam int FRAME_LEN = (VS + VB + VA + VF) * LL;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [7:0] DIR_BYTES [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                            8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
`ifdef DVP_SCROLL_EN
  localparam logic [7:0] F2_BYTES [4] = '{8'hFF, 8'hE0, 8'h07, 8'hFF};
`else
  localparam logic [7:0] F2_BYTES [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0};
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        vsync, href, busy, frame_done;
  logic [7:0]  data;

  dvp_cam_emulator #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vsync(vsync), .href(href), .data(data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t cyc=%0d: got %h expected %h", tag, $time, cyc, got, exp);
    end
  endtask

  // Reference model: position inside the frame timeline plus latched controls.
  bit          m_run = 1'b0;
  int          m_t = 0;
  int          m_sel = 0;
  logic [15:0] m_solid = 16'h0000;
  int          m_fc = 0;

  function automatic logic [15:0] ref_pixel(input int x, input int y);
    int xs;
    xs = x;
`ifdef DVP_SCROLL_EN
    xs = (x + m_fc) % HA;
`endif
    case (m_sel)
      0:       return BARS[xs / (HA / 8)];
      1:       return 16'(((xs % 32) << 11) | ((xs % 64) << 5) | (xs % 32));
      2:       return ((((xs / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 16'hFFFF : 16'h0000;
      default: return m_solid;
    endcase
  endfunction

  // Expected {vsync, href, data, busy, frame_done} for the current model state.
  function automatic logic [11:0] ref_outs();
    int line, h;
    logic v, hr, act;
    logic [15:0] px;
    logic [7:0] d;
    if (!m_run) return 12'h000;
    line = m_t / LL;
    h    = m_t % LL;
    v    = (line < VS);
    act  = (line >= VS + VB) && (line < VS + VB + VA);
    hr   = act && (h < 2 * HA);
    d    = 8'h00;
    if (hr) begin
      px = ref_pixel(h / 2, line - VS - VB);
      d  = ((h % 2) == 1) ? px[7:0] : px[15:8];
    end
    return {v, hr, d, 1'b1, (m_t == FRAME_LEN - 1)};
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_t   = 0;
    m_fc  = 0;
  endtask

  task automatic model_latch();
    m_run   = 1'b1;
    m_t     = 0;
    m_sel   = int'(pattern_sel);
    m_solid = solid_rgb;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    if (!m_run) begin
      if (en) model_latch();
    end else if (m_t == FRAME_LEN - 1) begin
      m_fc = (m_fc + 1) % 1024;
      if (en) model_latch();
      else m_run = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  function automatic logic [11:0] dut_outs();
    return {vsync, href, data, busy, frame_done};
  endfunction

  // One clock: update the model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    cyc++;
    check("outs", 32'(dut_outs()), 32'(ref_outs()));
  endtask

  int href_cnt;
  int k;

  initial begin
    // Reset held with en=1: everything stays low.
    reset = 1'b1;
    en    = 1'b1;
    #1;
    check("rst_outs", 32'(dut_outs()), 32'h0);
    repeat (3) begin
      step();
      check("rst_hold", 32'(dut_outs()), 32'h0);
    end

    // Directed frame: en during cycle 0, colour bars.
    reset       = 1'b0;
    en          = 1'b1;
    pattern_sel = 2'd0;
    cyc         = 0;
    href_cnt    = 0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 1 || c == 20) check("vs_high", 32'(vsync), 32'd1);
      if (c == 21) check("vs_low", 32'(vsync), 32'd0);
      if (c == 40 || c == 57) check("href_low", 32'(href), 32'd0);
      if (c >= 41 && c <= 56) begin
        check("href_high", 32'(href), 32'd1);
        check("bar_byte", 32'(data), 32'(DIR_BYTES[c - 41]));
      end
      if (c == 139) check("fd_early", 32'(frame_done), 32'd0);
      if (c == 140) check("fd_pulse", 32'(frame_done), 32'd1);
      if (c == 141) begin
        check("vs_rechain", 32'(vsync), 32'd1);
        check("busy_chain", 32'(busy), 32'd1);
      end
      if (c >= 181 && c <= 184) check("f2_byte", 32'(data), 32'(F2_BYTES[c - 181]));
      if (c >= 141 && c <= 280 && href) href_cnt++;
      if (c == 200) en = 1'b0;   // dropped mid-frame; frame must still finish
      if (c == 280) check("fd_after_drop", 32'(frame_done), 32'd1);
      if (c == 281) begin
        check("busy_idle", 32'(busy), 32'd0);
        check("vs_idle", 32'(vsync), 32'd0);
      end
      if (c > 281) check("no_href", 32'(href), 32'd0);
    end
    check("href_count", 32'(href_cnt), 32'd64);

    // Solid colour latched at frame start; later input changes ignored.
    pattern_sel = 2'd3;
    solid_rgb   = 16'hABCD;
    en          = 1'b1;
    step();
    pattern_sel = 2'd0;
    solid_rgb   = 16'h1234;
    en          = 1'b0;
    k = 0;
    repeat (FRAME_LEN) begin
      step();
      if (href) begin
        check("solid_byte", 32'(data), (k % 2 == 0) ? 32'hAB : 32'hCD);
        k++;
      end
    end
    check("solid_count", 32'(k), 32'd64);

    // Reset mid-ACTIVE: outputs drop immediately, restart one clock after release.
    pattern_sel = 2'd2;
    en          = 1'b1;
    repeat (45) step();
    check("pre_rst_href", 32'(href), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_async", 32'(dut_outs()), 32'h0);
    step();
    reset = 1'b0;
    step();
    check("restart_vs", 32'(vsync), 32'd1);

    // Randomized run: controls churn every cycle, en and reset change rarely.
    for (int i = 0; i < 4000; i++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      solid_rgb   = 16'($urandom);
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check("rnd_rst", 32'(dut_outs()), 32'h0);
        step();
        reset = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
